// File: rtl/regfile_pkg.sv
// Shared constants for the register file.
// REGFILE_BYPASS_EN: when defined, a read of the address being written in
// the same cycle returns the incoming write data instead of the old word.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 3;

    // Value every word and read register takes on reset or clear.
    localparam logic CLEAR_BIT = 1'b0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: address mux, optional write-to-read bypass
// (REGFILE_BYPASS_EN), and a valid flag marking a fresh read.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        clear,
    input  logic                                        re,
    input  logic [ADDR_WIDTH-1:0]                       raddr,
    input  logic                                        we,
    input  logic [ADDR_WIDTH-1:0]                       waddr,
    input  logic [DATA_WIDTH-1:0]                       wdata,
    input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]  words,
    output logic [DATA_WIDTH-1:0]                       rdata,
    output logic                                        valid
);

    localparam logic [DATA_WIDTH-1:0] CLEAR_WORD = {DATA_WIDTH{CLEAR_BIT}};

    logic                  zero_hit;
    logic                  bypass_hit;
    logic [DATA_WIDTH-1:0] rd_word;

    // Select the word to capture; word 0 reads as zero when ZERO_REG is set,
    // and that takes precedence over any bypass of a (discarded) write to it.
    always_comb begin
        zero_hit   = (ZERO_REG != 0) && (raddr == '0);
        bypass_hit = BYPASS_EN && we && (waddr == raddr);
        rd_word    = words[raddr];
        if (zero_hit) begin
            rd_word = CLEAR_WORD;
        end else if (bypass_hit) begin
            rd_word = wdata;
        end
    end

    // Capture on read enable; hold data but drop valid when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= CLEAR_WORD;
            valid <= 1'b0;
        end else if (clear) begin
            rdata <= CLEAR_WORD;
            valid <= 1'b0;
        end else if (re) begin
            rdata <= rd_word;
            valid <= 1'b1;
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with synchronous clear and optional
// read-only zero word. Build option REGFILE_BYPASS_EN selects write-to-read
// bypass on same-cycle same-address access (storage is unaffected).
module register_file
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re_a,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    input  logic                  re_b,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  valid_a,
    output logic                  valid_b
);

    localparam int unsigned           DEPTH      = 2**ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] CLEAR_WORD = {DATA_WIDTH{CLEAR_BIT}};

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic                             write_ok;

    // Writes to word 0 are dropped when it is the hard-wired zero register.
    always_comb begin
        write_ok = we && !((ZERO_REG != 0) && (waddr == '0));
    end

    // Storage array: async reset and sync clear both zero every word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= {DEPTH{CLEAR_WORD}};
        end else if (clear) begin
            mem <= {DEPTH{CLEAR_WORD}};
        end else if (write_ok) begin
            mem[waddr] <= wdata;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_port_a (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .re    (re_a),
        .raddr (raddr_a),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .words (mem),
        .rdata (rdata_a),
        .valid (valid_a)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_port_b (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .re    (re_b),
        .raddr (raddr_b),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .words (mem),
        .rdata (rdata_b),
        .valid (valid_b)
    );

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the bit width of every stored word.
REQ-002 Parameter ADDR_WIDTH, default 3, SHALL set the address width; depth = 2**ADDR_WIDTH words.
REQ-003 Parameter ZERO_REG, default 1, SHALL make word 0 read-only zero when 1.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 clear  input  1  SHALL be the synchronous clear-all request.
REQ-007 we  input  1  SHALL be the write enable.
REQ-008 waddr  input  ADDR_WIDTH  SHALL be the write address.
REQ-009 wdata  input  DATA_WIDTH  SHALL be the write data.
REQ-010 re_a, re_b  input  1 each  SHALL be the read enables for ports A and B.
REQ-011 raddr_a, raddr_b  input  ADDR_WIDTH each  SHALL be the read addresses.
REQ-012 rdata_a, rdata_b  output  DATA_WIDTH each  SHALL be the registered read data.
REQ-013 valid_a, valid_b  output  1 each  SHALL flag that rdata_x holds data requested in the previous cycle.

Function
REQ-014 Write: we=1 at a rising edge SHALL store wdata at waddr; we=0 SHALL leave storage unchanged.
REQ-015 With ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0.
REQ-016 Read latency SHALL be exactly 1 cycle: re_x=1 at edge N -> rdata_x = word[raddr_x] and valid_x=1 after edge N.
REQ-017 re_x=0 at an edge SHALL hold rdata_x at its previous value and drive valid_x=0.
REQ-018 Ports A and B SHALL be independent; both may read the same address in the same cycle with identical results.
REQ-019 Read and write of the same address in the same cycle SHALL follow the REGFILE_BYPASS_EN rule (REQ-025/026).
REQ-020 clear=1 at an edge SHALL zero all words, rdata_a, rdata_b, valid_a, valid_b; clear SHALL take priority over we and re_x in that cycle.
REQ-021 Addresses SHALL be used modulo depth; no out-of-range condition exists.

Reset
REQ-022 rst=0 SHALL immediately, independent of clk, zero all words, rdata_a, rdata_b, valid_a, valid_b.
REQ-023 Reset asserted mid-operation SHALL abort any pending read; first valid read SHALL follow the first edge with rst=1 and re_x=1.
REQ-024 A write at the edge where rst deasserts SHALL take effect normally.

Configuration
REQ-025 With REGFILE_BYPASS_EN defined, a same-cycle write and read of one non-zero address SHALL return the new wdata on rdata_x.
REQ-026 Without REGFILE_BYPASS_EN, that read SHALL return the value stored before the write; storage behaviour is identical in both builds.

Structure
REQ-027 Package regfile_pkg SHALL hold default DATA_WIDTH/ADDR_WIDTH constants and the reset/clear value constant (all zeros).
REQ-028 One sub-module, regfile_read_port, SHALL implement a single registered read port (mux, bypass, valid flag) and be instantiated twice.
REQ-029 Storage SHALL be a flat array of registers; no vendor memory primitives.

Verification (DATA_WIDTH=8, ADDR_WIDTH=3, ZERO_REG=1)
REQ-030 Reset: rst=0 mid-run -> rdata_a=rdata_b=8'h00, valid_a=valid_b=0 without a clock edge.
REQ-031 Write 8'h55 to addr 3, then re_a=1 raddr_a=3 -> one edge later rdata_a=8'h55, valid_a=1.
REQ-032 Write 8'hAA to addr 0, read addr 0 on both ports -> rdata_a=rdata_b=8'h00.
REQ-033 Addr 5 holds 8'h11; same edge we=1 waddr=5 wdata=8'hFF, re_b=1 raddr_b=5 -> rdata_b=8'hFF with REGFILE_BYPASS_EN, 8'h11 without; next read returns 8'hFF in both.
REQ-034 Fill addrs 1..7 with 8'h01..8'h07, assert clear with we=1 waddr=2 wdata=8'hEE -> all reads then return 8'h00.
REQ-035 re_a=0 after valid read of 8'h55 -> rdata_a stays 8'h55, valid_a=0.
